lift_input_dispatch: RTL and testbench
======================================

# lift_input_dispatch

Consumes the BRAM read stream produced by the lift-stage address generator during the read phase (`read_write=0`): one residue word per cycle, tagged with processor select and memory select. Collects 6 words (small lift) or 7 words (big lift: 6 mod-q shares plus 1 mod-p share) into a complete coefficient group. Hands each finished group to the lift datapath through a valid/ready handshake, using two ping-pong banks so that collection and hand-off overlap.

## Interface
- `DATA_W`, 30, width of one residue word
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `lift_mode`  in  1  0 = small (6 slots), 1 = big (7 slots); sampled on slot 0 only
- `in_valid`  in  1  BRAM word valid this cycle (caller delays addr-gen `enable` by one cycle)
- `in_data`  in  DATA_W  BRAM read word
- `in_proc_sel`  in  3  slot index 0..6 (already aligned to data by the addr gen)
- `in_mem_sel`  in  4  memory select tag; captured with slot 0
- `fill_ok`  out  1  a bank is free or currently filling; controller must drop `enable` when low
- `out_valid`  out  1  a full group is presented
- `out_ready`  in  1  lift datapath accepts the group
- `out_data`  out  7*DATA_W  slot k at bits [k*DATA_W +: DATA_W]; slot 6 is zero in small mode
- `out_mem_sel`  out  4  tag captured with slot 0 of the presented group
- `out_mode`  out  1  `lift_mode` captured with slot 0 of the presented group
- `grp_cnt`  out  9  groups handed off, modulo 512 (matches BRAM depth)
- `overflow`  out  1  sticky: word arrived while no bank was available
- `seq_err`  out  1  sticky: slot order violation (only with the check macro)

## Operation
- Two banks, each with state EMPTY, FILLING or FULL. A fill pointer and a drain pointer each toggle 0/1.
- Fill FSM, state IDLE:
  - A valid word with slot 0 and the fill bank EMPTY: write slot 0; capture `lift_mode` and `in_mem_sel`; bank becomes FILLING; go to COLLECT with expected slot 1.
- Fill FSM, state COLLECT:
  - A valid word is written to its slot.
  - When the slot equals last (5 if the captured mode is 0, 6 if 1): bank becomes FULL, fill pointer toggles, return to IDLE.
- A group's mode is fixed at slot 0. A `lift_mode` change mid-group is ignored.
- In small mode, slot 6 of the bank is cleared when slot 0 is written.
- Drain side:
  - `out_valid` = drain bank FULL.
  - A handshake (`out_valid & out_ready`) sets the bank EMPTY, toggles the drain pointer and increments `grp_cnt` (511 wraps to 0).
- Fill completion and drain handshake in the same cycle are both honoured. If they hit the same bank, the drain applies to the old contents; this cannot happen while the pointers are consistent.
- `fill_ok` = fill bank EMPTY, or FSM in COLLECT.
- A valid word with `fill_ok` low: word dropped, `overflow` set, FSM unchanged.
- Reset: all outputs 0, banks EMPTY, pointers 0, FSM IDLE, stickies cleared. Reset asserted mid-group discards the partial group.

## Timing
- Bank write is registered. The last slot accepted in cycle t gives `out_valid`=1 in cycle t+1.
- `out_data`, `out_mem_sel` and `out_mode` are held stable while `out_valid` is high and `out_ready` is low.
- Throughput: one word per cycle sustained when `out_ready` is held high. No bubble is needed between groups.
- Back-to-back groups fill the second bank while the first waits.
- With both banks FULL, `fill_ok` falls in the cycle after the second bank completes.
- The controller sees `fill_ok` low and removes `enable`. Because BRAM read latency is 1, one in-flight word can still arrive. Callers gate `enable` with `fill_ok` combinationally to avoid overflow.

## Configuration
- `LIFT_DISPATCH_SEQ_CHECK_EN` defined:
  - In COLLECT, a slot not equal to the expected slot sets `seq_err`, discards the partial group (bank EMPTY) and returns to IDLE.
  - If the offending word is slot 0, it starts a new group in the same cycle.
  - In IDLE, non-zero slots are dropped and set `seq_err`.
- Undefined:
  - No expected-slot tracking. Words are written at `in_proc_sel`; completion is on the last slot only.
  - `seq_err` is tied to 0.

## Test plan
- Reset, then small mode: words 0x10..0x15 on slots 0..5, `out_ready`=1 → `out_valid` the cycle after slot 5; `out_data` slots 0..5 = 0x10..0x15, slot 6 = 0; `grp_cnt`=1.
- Big mode, `in_mem_sel`=4'h3 on slot 0, then 4'h7 on slot 6 → `out_mode`=1, `out_mem_sel`=4'h3, slot 6 holds the slot-6 word.
- `out_ready`=0, three back-to-back small groups → two banks FULL, `fill_ok`=0; the third group's first word sets `overflow`. Raise `out_ready` → groups 1 and 2 emerge in order with data intact.
- 1024 small groups, `out_ready`=1 → `grp_cnt` wraps to 0 at group 512 and again at 1024; no `out_valid` gaps beyond one per group.
- With the macro, slots 0,1,3 → `seq_err`=1, no `out_valid`. A following clean group 0..5 is delivered correctly. Without the macro, the same stimulus gives `seq_err`=0.
- Assert `rst` after slot 3 of a group → all outputs 0. A fresh group after reset is delivered with no stale slots.

Source files
------------

// File: rtl/lift_input_dispatch.sv
// rtl/lift_input_dispatch.sv - collects lift-stage BRAM residue words into 6/7-slot groups, ping-pong handoff
// Optional slot-order checking: define LIFT_DISPATCH_SEQ_CHECK_EN.
module lift_input_dispatch #(
    parameter int DATA_W = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lift_mode,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [2:0]          in_proc_sel,
    input  logic [3:0]          in_mem_sel,
    output logic                fill_ok,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7*DATA_W-1:0] out_data,
    output logic [3:0]          out_mem_sel,
    output logic                out_mode,
    output logic [8:0]          grp_cnt,
    output logic                overflow,
    output logic                seq_err
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_state_t;
    typedef enum logic {S_IDLE, S_COLLECT} fill_state_t;

    logic [DATA_W-1:0] bank_data [2][7];
    logic [3:0]        bank_msel [2];
    logic              bank_mode [2];
    bank_state_t       bank_st   [2];
    logic              fill_ptr;
    logic              drain_ptr;
    fill_state_t       fsm;

    logic       accept;
    logic       do_start;
    logic       do_write;
    logic       do_done;
    logic       drain_fire;
    logic [2:0] last_slot;

`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
    logic [2:0] exp_slot;
    logic       do_abort;
    logic       seq_flag;
`endif

    // The group's mode lives in the bank, captured with slot 0.
    assign last_slot  = bank_mode[fill_ptr] ? 3'd6 : 3'd5;
    assign fill_ok    = (bank_st[fill_ptr] == B_EMPTY) || (fsm == S_COLLECT);
    assign out_valid  = (bank_st[drain_ptr] == B_FULL);
    assign drain_fire = out_valid && out_ready;

    always_comb begin
        accept   = in_valid && fill_ok;
`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
        do_start = accept && (in_proc_sel == 3'd0);
        do_write = accept && (fsm == S_COLLECT) && (in_proc_sel == exp_slot);
        do_abort = accept && (fsm == S_COLLECT) && (in_proc_sel != exp_slot);
        seq_flag = accept && (in_proc_sel != ((fsm == S_COLLECT) ? exp_slot : 3'd0));
`else
        do_start = accept && (fsm == S_IDLE) && (in_proc_sel == 3'd0);
        do_write = accept && (fsm == S_COLLECT) && (in_proc_sel <= last_slot);
`endif
        do_done  = do_write && (in_proc_sel == last_slot);
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 7; k++) begin
            out_data[k*DATA_W +: DATA_W] = bank_data[drain_ptr][k];
        end
    end

    assign out_mem_sel = bank_msel[drain_ptr];
    assign out_mode    = bank_mode[drain_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 7; k++) begin
                    bank_data[b][k] <= '0;
                end
                bank_msel[b] <= '0;
                bank_mode[b] <= 1'b0;
                bank_st[b]   <= B_EMPTY;
            end
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            fsm       <= S_IDLE;
            grp_cnt   <= '0;
            overflow  <= 1'b0;
`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
            exp_slot  <= 3'd0;
            seq_err   <= 1'b0;
`endif
        end else begin
            // Drain first so a same-cycle fill update on that bank takes precedence.
            if (drain_fire) begin
                bank_st[drain_ptr] <= B_EMPTY;
                drain_ptr          <= ~drain_ptr;
                grp_cnt            <= grp_cnt + 9'd1;
            end

            if (in_valid && !fill_ok) begin
                overflow <= 1'b1;
            end

`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
            if (seq_flag) begin
                seq_err <= 1'b1;
            end
            if (do_abort) begin
                bank_st[fill_ptr] <= B_EMPTY;
                fsm               <= S_IDLE;
            end
`endif

            if (do_start) begin
                bank_data[fill_ptr][0] <= in_data;
                if (!lift_mode) begin
                    bank_data[fill_ptr][6] <= '0;
                end
                bank_mode[fill_ptr] <= lift_mode;
                bank_msel[fill_ptr] <= in_mem_sel;
                bank_st[fill_ptr]   <= B_FILLING;
                fsm                 <= S_COLLECT;
`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
                exp_slot            <= 3'd1;
`endif
            end

            if (do_write) begin
                bank_data[fill_ptr][in_proc_sel] <= in_data;
                if (do_done) begin
                    bank_st[fill_ptr] <= B_FULL;
                    fill_ptr          <= ~fill_ptr;
                    fsm               <= S_IDLE;
                end
`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
                else begin
                    exp_slot <= in_proc_sel + 3'd1;
                end
`endif
            end
        end
    end

`ifndef LIFT_DISPATCH_SEQ_CHECK_EN
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_lift_input_dispatch.sv
// tb/tb_lift_input_dispatch.sv - directed self-checking bench for lift_input_dispatch
module tb_lift_input_dispatch;

    localparam int DW = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lift_mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_proc_sel = '0;
    logic [3:0]    in_mem_sel = '0;
    logic          fill_ok;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7*DW-1:0] out_data;
    logic [3:0]    out_mem_sel;
    logic          out_mode;
    logic [8:0]    grp_cnt;
    logic          overflow;
    logic          seq_err;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;

    lift_input_dispatch #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .lift_mode(lift_mode), .in_valid(in_valid),
        .in_data(in_data), .in_proc_sel(in_proc_sel), .in_mem_sel(in_mem_sel),
        .fill_ok(fill_ok), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_mem_sel(out_mem_sel), .out_mode(out_mode),
        .grp_cnt(grp_cnt), .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) hs_cnt++;
    end

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] slot, input logic [DW-1:0] d,
                        input logic m, input logic [3:0] ms);
        in_valid = 1'b1;
        in_proc_sel = slot;
        in_data = d;
        lift_mode = m;
        in_mem_sel = ms;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [7*DW-1:0] grp(input logic [DW-1:0] base, input int n);
        logic [7*DW-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid, out_data, out_mem_sel, out_mode, grp_cnt, overflow, seq_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h msel=%h mode=%b cnt=%0d ovf=%b serr=%b want all 0",
                     out_valid, out_data, out_mem_sel, out_mode, grp_cnt, overflow, seq_err);
        end
        tests++;
        if (fill_ok !== 1'b1) begin fails++; $display("FAIL reset_fill_ok: got %b want 1", fill_ok); end
    endtask

    task automatic test_small();
        logic [7*DW-1:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'h10 + k), 1'b0, 4'h0);
        exp = grp(DW'(32'h10), 6);
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL small_valid: got %b want 1", out_valid); end
        tests++;
        if (out_data !== exp) begin fails++; $display("FAIL small_data: got %h want %h", out_data, exp); end
        @(posedge clk); #1;
        tests++;
        if (grp_cnt !== 9'd1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL small_cnt: got cnt=%0d valid=%b want cnt=1 valid=0", grp_cnt, out_valid);
        end
    endtask

    task automatic test_big();
        logic [7*DW-1:0] exp;
        do_reset();
        for (int k = 0; k < 7; k++) send(3'(k), DW'(32'h20 + k), (k == 0), (k == 0) ? 4'h3 : 4'h7);
        exp = grp(DW'(32'h20), 7);
        tests++;
        if (out_valid !== 1'b1 || out_mode !== 1'b1 || out_mem_sel !== 4'h3) begin
            fails++; $display("FAIL big_tags: got valid=%b mode=%b msel=%h want 1 1 3", out_valid, out_mode, out_mem_sel);
        end
        tests++;
        if (out_data !== exp) begin fails++; $display("FAIL big_data: got %h want %h", out_data, exp); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp || out_mem_sel !== 4'h3) begin
            fails++; $display("FAIL big_hold: got valid=%b data=%h msel=%h want 1 %h 3", out_valid, out_data, out_mem_sel, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (grp_cnt !== 9'd1) begin fails++; $display("FAIL big_cnt: got %0d want 1", grp_cnt); end
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'h80 + k), 1'b0, 4'h1);
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'h90 + k), 1'b0, 4'h2);
        exp = grp(DW'(32'h90), 6);
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp || out_mode !== 1'b0) begin
            fails++; $display("FAIL small_after_big: got valid=%b mode=%b data=%h want 1 0 %h", out_valid, out_mode, out_data, exp);
        end
    endtask

    task automatic test_seq();
        logic [7*DW-1:0] exp;
        logic            exp_err;
`ifdef LIFT_DISPATCH_SEQ_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        out_ready = 1'b1;
        send(3'd0, DW'(32'h40), 1'b0, 4'h0);
        send(3'd1, DW'(32'h41), 1'b0, 4'h0);
        send(3'd3, DW'(32'h43), 1'b0, 4'h0);
        tests++;
        if (out_valid !== 1'b0 || seq_err !== exp_err) begin
            fails++; $display("FAIL seq_bad: got valid=%b serr=%b want 0 %b", out_valid, seq_err, exp_err);
        end
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'h50 + k), 1'b0, 4'h0);
        exp = grp(DW'(32'h50), 6);
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            fails++; $display("FAIL seq_clean: got valid=%b data=%h want 1 %h", out_valid, out_data, exp);
        end
    endtask

    task automatic test_wrap();
        int hs0;
        do_reset();
        out_ready = 1'b1;
        hs0 = hs_cnt;
        for (int g = 0; g < 1024; g++) begin
            for (int k = 0; k < 6; k++) send(3'(k), DW'(g * 8 + k), 1'b0, 4'h0);
            if (g == 511) begin
                tests++;
                if (grp_cnt !== 9'd511) begin fails++; $display("FAIL wrap_511: got %0d want 511", grp_cnt); end
            end
            if (g == 512) begin
                tests++;
                if (grp_cnt !== 9'd0) begin fails++; $display("FAIL wrap_512: got %0d want 0", grp_cnt); end
            end
        end
        @(posedge clk); #1;
        tests++;
        if (grp_cnt !== 9'd0) begin fails++; $display("FAIL wrap_1024: got %0d want 0", grp_cnt); end
        tests++;
        if (hs_cnt - hs0 !== 1024) begin fails++; $display("FAIL wrap_handshakes: got %0d want 1024", hs_cnt - hs0); end
    endtask

    task automatic test_backpressure();
        logic [7*DW-1:0] exp_a, exp_b;
        do_reset();
        exp_a = grp(DW'(32'h30), 6);
        exp_b = grp(DW'(32'h60), 6);
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'h30 + k), 1'b0, 4'h0);
        tests++;
        if (fill_ok !== 1'b1) begin fails++; $display("FAIL bp_one_full: got fill_ok=%b want 1", fill_ok); end
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'h60 + k), 1'b0, 4'h0);
        tests++;
        if (fill_ok !== 1'b0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_both_full: got fill_ok=%b valid=%b want 0 1", fill_ok, out_valid);
        end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL bp_no_ovf_yet: got %b want 0", overflow); end
        send(3'd0, DW'(32'h70), 1'b0, 4'h0);
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        out_ready = 1'b1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp_a) begin
            fails++; $display("FAIL bp_group1: got valid=%b data=%h want 1 %h", out_valid, out_data, exp_a);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp_b || grp_cnt !== 9'd1) begin
            fails++; $display("FAIL bp_group2: got valid=%b cnt=%0d data=%h want 1 1 %h", out_valid, grp_cnt, out_data, exp_b);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || grp_cnt !== 9'd2) begin
            fails++; $display("FAIL bp_drained: got valid=%b cnt=%0d want 0 2", out_valid, grp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [7*DW-1:0] exp;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(3'(k), DW'(32'hA0 + k), 1'b1, 4'h9);
        rst = 1'b1;
        #2;
        tests++;
        if ({out_valid, out_data, out_mem_sel, out_mode, grp_cnt, overflow, seq_err} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got valid=%b data=%h msel=%h mode=%b cnt=%0d ovf=%b want all 0",
                     out_valid, out_data, out_mem_sel, out_mode, grp_cnt, overflow);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) send(3'(k), DW'(32'hB0 + k), 1'b0, 4'h5);
        exp = grp(DW'(32'hB0), 6);
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp || out_mem_sel !== 4'h5 || out_mode !== 1'b0) begin
            fails++; $display("FAIL rst_mid_fresh: got valid=%b msel=%h mode=%b data=%h want 1 5 0 %h",
                              out_valid, out_mem_sel, out_mode, out_data, exp);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_big();
        test_seq();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
